// File: rtl/reg_file_param.sv
// Register file: 2 async reads, primary write port, valid/ready external-load port with a 1-entry pending slot.
// Uncontended load visible 1 cycle after acceptance; ext_ready drops while a load is pending; `REGFILE_BYPASS_EN enables write-to-read forwarding.
module reg_file_param #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  output logic [DATA_WIDTH-1:0] read_out1,
  output logic [DATA_WIDTH-1:0] read_out2,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  ext_valid,
  input  logic [ADDR_WIDTH-1:0] ext_reg,
  input  logic [DATA_WIDTH-1:0] ext_data,
  output logic                  ext_ready,
  output logic                  ext_done
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] pend_reg;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  capture;
  logic                  done_set;

  // Addresses past NUM_REGS and the hardwired zero register are neither stored nor read.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] array_rd(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (writable(a)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(a) == i) v = regs[i];
      end
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ext_valid && reg_write) state_nxt = PEND;
      PEND:    if (!reg_write || (write_reg == pend_reg)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single array write port: primary write always wins, external/pending data takes free edges.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = write_reg;
    wr_data  = write_data;
    capture  = 1'b0;
    done_set = 1'b0;
    case (state)
      IDLE: begin
        if (reg_write) begin
          wr_en   = 1'b1;
          capture = ext_valid;
        end else if (ext_valid) begin
          wr_en    = 1'b1;
          wr_addr  = ext_reg;
          wr_data  = ext_data;
          done_set = 1'b1;
        end
      end
      PEND: begin
        wr_en = 1'b1;
        if (reg_write) begin
          done_set = (write_reg == pend_reg);
        end else begin
          wr_addr  = pend_reg;
          wr_data  = pend_data;
          done_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ext_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend_reg  <= '0;
      pend_data <= '0;
      ext_done  <= 1'b0;
    end else begin
      if (wr_en && writable(wr_addr)) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (int'(wr_addr) == i) regs[i] <= wr_data;
        end
      end
      if (capture) begin
        pend_reg  <= ext_reg;
        pend_data <= ext_data;
      end
      ext_done <= done_set;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_out1 = array_rd(read1);
    read_out2 = array_rd(read2);
    if (reg_write && writable(write_reg)) begin
      if (read1 == write_reg) read_out1 = write_data;
      if (read2 == write_reg) read_out2 = write_data;
    end
  end
`else
  always_comb begin
    read_out1 = array_rd(read1);
    read_out2 = array_rd(read2);
  end
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: two instances (ZERO_REG=0 and ZERO_REG=1) share all inputs.
module tb_reg_file_param;

  logic        clk;
  logic        reset_n;
  logic [1:0]  read1, read2;
  logic        reg_write;
  logic [1:0]  write_reg;
  logic [15:0] write_data;
  logic        ext_valid;
  logic [1:0]  ext_reg;
  logic [15:0] ext_data;

  logic [15:0] a_out1, a_out2, b_out1, b_out2;
  logic        a_ready, a_done, b_ready, b_done;

  int checks = 0;
  int errors = 0;

  reg_file_param #(.DATA_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(2), .ZERO_REG(0)) u_a (
    .clk(clk), .reset_n(reset_n), .read1(read1), .read2(read2),
    .read_out1(a_out1), .read_out2(a_out2), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .ext_valid(ext_valid), .ext_reg(ext_reg), .ext_data(ext_data),
    .ext_ready(a_ready), .ext_done(a_done));

  reg_file_param #(.DATA_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(2), .ZERO_REG(1)) u_b (
    .clk(clk), .reset_n(reset_n), .read1(read1), .read2(read2),
    .read_out1(b_out1), .read_out2(b_out2), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .ext_valid(ext_valid), .ext_reg(ext_reg), .ext_data(ext_data),
    .ext_ready(b_ready), .ext_done(b_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        ev;
    logic [1:0]  er;
    logic [15:0] ed;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic [15:0] x1;
    logic [15:0] x2;
    logic        rdy;
    logic        done;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic rw, input logic [1:0] wr, input logic [15:0] wd,
                              input logic ev, input logic [1:0] er, input logic [15:0] ed,
                              input logic [1:0] r1, input logic [1:0] r2,
                              input logic [15:0] x1, input logic [15:0] x2,
                              input logic rdy, input logic done);
    vec_t v;
    v.rw = rw; v.wr = wr; v.wd = wd; v.ev = ev; v.er = er; v.ed = ed;
    v.r1 = r1; v.r2 = r2; v.x1 = x1; v.x2 = x2; v.rdy = rdy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reg_write = 1'b0; write_reg = '0; write_data = '0;
    ext_valid = 1'b0; ext_reg = '0; ext_data = '0;
  endtask

  // Drive at negedge, take one posedge, drop the write strobes, then sample.
  task automatic drive(input logic rw, input logic [1:0] wr, input logic [15:0] wd,
                       input logic ev, input logic [1:0] er, input logic [15:0] ed);
    @(negedge clk);
    reg_write = rw; write_reg = wr; write_data = wd;
    ext_valid = ev; ext_reg = er; ext_data = ed;
    @(posedge clk);
    #1 idle_inputs();
    #1;
  endtask

  task automatic read_both(input logic [1:0] a1, input logic [1:0] a2);
    read1 = a1; read2 = a2;
    #1;
  endtask

  logic [15:0] bypass_exp;

  initial begin
    reset_n = 1'b0;
    read1 = '0; read2 = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Preload, with an external load on the last edge so a done pulse would be due at reset.
    drive(1'b1, 2'd0, 16'h1111, 1'b0, 2'd0, 16'h0);
    drive(1'b1, 2'd1, 16'h2222, 1'b0, 2'd0, 16'h0);
    drive(1'b1, 2'd2, 16'h3333, 1'b0, 2'd0, 16'h0);
    read_both(2'd1, 2'd2);
    chk("preload_a_r1", a_out1, 16'h2222);
    chk("preload_b_r2", b_out2, 16'h3333);
    @(negedge clk);
    ext_valid = 1'b1; ext_reg = 2'd3; ext_data = 16'h4444;
    reset_n = 1'b0;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk) reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      read_both(2'(r), 2'(r));
      chk($sformatf("reset_a_reg%0d", r), a_out1, 16'h0);
      chk($sformatf("reset_b_reg%0d", r), b_out2, 16'h0);
    end
    chk("reset_a_ready", 16'(a_ready), 16'h1);
    chk("reset_a_done",  16'(a_done),  16'h0);
    chk("reset_b_done",  16'(b_done),  16'h0);

    //            rw    wr    wd        ev    er    ed        r1    r2    x1        x2        rdy   done
    vecs[0]  = mk(1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0, 16'h0000, 2'd2, 2'd0, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0042, 2'd1, 2'd2, 16'h0042, 16'hBEEF, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd3, 16'h0042, 16'h0000, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 2'd1, 16'h0011, 1'b1, 2'd3, 16'h00AA, 2'd1, 2'd3, 16'h0011, 16'h0000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 2'd2, 16'h2222, 1'b1, 2'd0, 16'h5555, 2'd2, 2'd3, 16'h2222, 16'h0000, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd0, 16'h00AA, 16'h0000, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd2, 2'd1, 16'h2222, 16'h0011, 1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 2'd2, 16'h3333, 1'b1, 2'd3, 16'h0BBB, 2'd3, 2'd2, 16'h00AA, 16'h3333, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 2'd3, 16'h1234, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd2, 16'h1234, 16'h3333, 1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd0, 16'h1234, 16'h0000, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 2'd0, 16'hFFFF, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 16'h7777, 2'd0, 2'd1, 16'h7777, 16'h0011, 1'b1, 1'b1);
    vecs[12] = mk(1'b1, 2'd0, 16'h9999, 1'b1, 2'd1, 16'h0ABC, 2'd0, 2'd1, 16'h9999, 16'h0011, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd1, 16'h9999, 16'h0ABC, 1'b1, 1'b1);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].ev, vecs[i].er, vecs[i].ed);
      read_both(vecs[i].r1, vecs[i].r2);
      chk($sformatf("v%0d_a_r1", i), a_out1, vecs[i].x1);
      chk($sformatf("v%0d_a_r2", i), a_out2, vecs[i].x2);
      // The ZERO_REG=1 instance reads 0 from register 0 and otherwise matches.
      chk($sformatf("v%0d_b_r1", i), b_out1, (vecs[i].r1 == 2'd0) ? 16'h0 : vecs[i].x1);
      chk($sformatf("v%0d_b_r2", i), b_out2, (vecs[i].r2 == 2'd0) ? 16'h0 : vecs[i].x2);
      chk($sformatf("v%0d_a_ready", i), 16'(a_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d_a_done", i),  16'(a_done),  16'(vecs[i].done));
      chk($sformatf("v%0d_b_ready", i), 16'(b_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d_b_done", i),  16'(b_done),  16'(vecs[i].done));
    end

    // Same-cycle read during a primary write to reg1 (currently 0ABC).
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 16'hCAFE;
`else
    bypass_exp = 16'h0ABC;
`endif
    @(negedge clk);
    read1 = 2'd1; read2 = 2'd0;
    reg_write = 1'b1; write_reg = 2'd1; write_data = 16'hCAFE;
    #1;
    chk("same_cycle_a_r1", a_out1, bypass_exp);
    chk("same_cycle_b_r1", b_out1, bypass_exp);
    chk("same_cycle_a_r2_other", a_out2, 16'h9999);
    @(posedge clk);
    #1 idle_inputs();
    #1;
    chk("after_write_a_r1", a_out1, 16'hCAFE);
    chk("after_write_b_r1", b_out1, 16'hCAFE);

    // Reset while a load is pending: the pending entry must never commit.
    drive(1'b1, 2'd2, 16'h4444, 1'b1, 2'd3, 16'h00AA);
    chk("pend_before_reset_a_ready", 16'(a_ready), 16'h0);
    chk("pend_before_reset_b_ready", 16'(b_ready), 16'h0);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      read_both(2'd3, 2'd2);
      chk("rst_pend_a_reg3", a_out1, 16'h0);
      chk("rst_pend_b_reg3", b_out1, 16'h0);
      chk("rst_pend_a_reg2", a_out2, 16'h0);
      chk("rst_pend_a_done", 16'(a_done), 16'h0);
      chk("rst_pend_b_done", 16'(b_done), 16'h0);
      chk("rst_pend_b_ready", 16'(b_ready), 16'h1);
    end

    // ZERO_REG=1: writing reg0 has no effect.
    drive(1'b1, 2'd0, 16'hFFFF, 1'b0, 2'd0, 16'h0);
    read_both(2'd0, 2'd0);
    chk("zero_reg_b_r1", b_out1, 16'h0);
    chk("zero_reg_a_r1", a_out1, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
